// File: rtl/vc_fifo_bank.sv
// Multi-channel FIFO: one banked array, NUM_CH circular queues addressed as {channel, pointer}.
// Optional `VC_FIFO_COUNT_EN adds the per-channel occupancy output port.
module vc_fifo_bank #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [CH_W-1:0]        push_ch,
  input  logic [DATA_SIZE-1:0]   data_in,
  input  logic                   pop,
  input  logic [CH_W-1:0]        pop_ch,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic                   valid_out,
  output logic [NUM_CH-1:0]      full,
  output logic [NUM_CH-1:0]      empty,
  output logic [NUM_CH-1:0]      almost_full,
  output logic [NUM_CH-1:0]      almost_empty,
  output logic [NUM_CH-1:0]      overflow_err,
  output logic [NUM_CH-1:0]      underflow_err
`ifdef VC_FIFO_COUNT_EN
  ,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0] occupancy
`endif
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int CNT_W = ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_T    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T    = CNT_W'(AE_THRESH);

  logic [DATA_SIZE-1:0] mem_q [NUM_CH*DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q [NUM_CH];
  logic [ADDR_SIZE-1:0] wr_ptr_d [NUM_CH];
  logic [ADDR_SIZE-1:0] rd_ptr_q [NUM_CH];
  logic [ADDR_SIZE-1:0] rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]     cnt_q    [NUM_CH];
  logic [CNT_W-1:0]     cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic [NUM_CH-1:0]    unf_q, unf_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 push_acc, pop_acc;

  always_comb begin
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      full[c]         = (cnt_q[c] == CNT_MAX);
      empty[c]        = (cnt_q[c] == '0);
      almost_full[c]  = (cnt_q[c] >= AF_T);
      almost_empty[c] = (cnt_q[c] <= AE_T);
    end
  end

  // A full channel still accepts a push when the same cycle pops it: wr_ptr == rd_ptr,
  // so the write lands in the slot being read out.
  assign pop_acc  = pop && !empty[pop_ch];
  assign push_acc = push && (!full[push_ch] || (pop_acc && (pop_ch == push_ch)));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    valid_d  = pop_acc;
    if (pop_acc) begin
      dout_d           = mem_q[{pop_ch, rd_ptr_q[pop_ch]}];
      rd_ptr_d[pop_ch] = rd_ptr_q[pop_ch] + 1'b1;
    end else if (pop) begin
      unf_d[pop_ch] = 1'b1;
    end
    if (push_acc) begin
      wr_ptr_d[push_ch] = wr_ptr_q[push_ch] + 1'b1;
    end else if (push) begin
      ovf_d[push_ch] = 1'b1;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case ({push_acc && (push_ch == CH_W'(c)), pop_acc && (pop_ch == CH_W'(c))})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      ovf_q   <= '0;
      unf_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[{push_ch, wr_ptr_q[push_ch]}] <= data_in;
  end

  assign data_out      = dout_q;
  assign valid_out     = valid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef VC_FIFO_COUNT_EN
  always_comb begin
    occupancy = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      occupancy[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Randomized + directed bench for vc_fifo_bank against a queue-per-channel reference model.
// Checks occupancy too when VC_FIFO_COUNT_EN is defined.
module tb_vc_fifo_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic [1:0] push_ch = '0;
  logic [9:0] data_in = '0;
  logic       pop = 1'b0;
  logic [1:0] pop_ch = '0;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] full, empty, almost_full, almost_empty, overflow_err, underflow_err;
`ifdef VC_FIFO_COUNT_EN
  logic [15:0] occupancy;
`endif

  vc_fifo_bank #(
    .DATA_SIZE(10), .ADDR_SIZE(3), .NUM_CH(4), .CH_W(2), .AF_THRESH(6), .AE_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_ch(push_ch), .data_in(data_in),
    .pop(pop), .pop_ch(pop_ch), .data_out(data_out), .valid_out(valid_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
`ifdef VC_FIFO_COUNT_EN
    , .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] mq [4][$];
  logic [9:0] exp_dout;
  logic       exp_valid;
  logic [3:0] exp_ovf, exp_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = '0;
    exp_unf   = '0;
  endtask

  task automatic check_all();
    logic [3:0] e, f, af, ae;
    for (int c = 0; c < 4; c++) begin
      e[c]  = (mq[c].size() == 0);
      f[c]  = (mq[c].size() == 8);
      af[c] = (mq[c].size() >= 6);
      ae[c] = (mq[c].size() <= 1);
    end
    check_eq("valid_out", 32'(valid_out), 32'(exp_valid));
    check_eq("data_out", 32'(data_out), 32'(exp_dout));
    check_eq("empty", 32'(empty), 32'(e));
    check_eq("full", 32'(full), 32'(f));
    check_eq("almost_full", 32'(almost_full), 32'(af));
    check_eq("almost_empty", 32'(almost_empty), 32'(ae));
    check_eq("overflow_err", 32'(overflow_err), 32'(exp_ovf));
    check_eq("underflow_err", 32'(underflow_err), 32'(exp_unf));
`ifdef VC_FIFO_COUNT_EN
    for (int c = 0; c < 4; c++) begin
      logic [3:0] fld;
      fld = occupancy[c*4 +: 4];
      check_eq("occupancy", 32'(fld), 32'(mq[c].size()));
    end
`endif
  endtask

  // Called at posedge+1; applies one cycle of stimulus and checks the result.
  task automatic step(input logic ph, input logic [1:0] pc, input logic [9:0] d,
                      input logic pp, input logic [1:0] qc);
    logic pop_ok, push_ok;
    push = ph; push_ch = pc; data_in = d;
    pop = pp;  pop_ch = qc;
    pop_ok  = pp && (mq[qc].size() > 0);
    push_ok = ph && ((mq[pc].size() < 8) || (pop_ok && (pc == qc)));
    @(posedge clk);
    #1;
    exp_valid = pop_ok;
    if (pop_ok) exp_dout = mq[qc].pop_front();
    else if (pp) exp_unf[qc] = 1'b1;
    if (push_ok) mq[pc].push_back(d);
    else if (ph) exp_ovf[pc] = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    do_reset();
    step(0, 0, 0, 0, 0);
    check_eq("rst_empty", 32'(empty), 32'hF);
    check_eq("rst_ae", 32'(almost_empty), 32'hF);
    check_eq("rst_full", 32'(full), 32'h0);

    // ch2: fill with 001..008, drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1, 2, 10'(i), 0, 0);
      check_eq("ch2_af", 32'(almost_full[2]), 32'(i >= 6));
    end
    check_eq("ch2_full", 32'(full[2]), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1, 2);
      check_eq("ch2_data", 32'(data_out), 32'(i));
      check_eq("ch2_valid", 32'(valid_out), 32'h1);
    end
    step(0, 0, 0, 0, 0);
    check_eq("ch2_empty", 32'(empty[2]), 32'h1);

    // ch0 overflow leaves contents intact
    for (int i = 0; i < 8; i++) step(1, 0, 10'h0A0 + 10'(i), 0, 0);
    step(1, 0, 10'h3FF, 0, 0);
    check_eq("ovf0", 32'(overflow_err[0]), 32'h1);
    step(0, 0, 0, 1, 0);
    check_eq("ovf0_data", 32'(data_out), 32'h0A0);

    // ch3 underflow leaves pointers intact
    step(0, 0, 0, 1, 3);
    check_eq("unf3", 32'(underflow_err[3]), 32'h1);
    check_eq("unf3_valid", 32'(valid_out), 32'h0);
    step(1, 3, 10'h2C3, 0, 0);
    step(0, 0, 0, 1, 3);
    check_eq("unf3_data", 32'(data_out), 32'h2C3);
    // empty channel: same-cycle push+pop, no bypass
    step(1, 3, 10'h111, 1, 3);
    check_eq("nobypass_valid", 32'(valid_out), 32'h0);
    step(0, 0, 0, 1, 3);
    check_eq("nobypass_data", 32'(data_out), 32'h111);

    // ch1 full: push+pop same cycle reuses the freed slot
    for (int i = 0; i < 8; i++) step(1, 1, 10'h040 + 10'(i), 0, 0);
    step(1, 1, 10'h155, 1, 1);
    check_eq("full_pp_data", 32'(data_out), 32'h040);
    check_eq("full_pp_full", 32'(full[1]), 32'h1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check_eq("wrap_data", 32'(data_out), 32'h155);
    step(1, 1, 10'h0AA, 0, 0);
    step(1, 0, 10'h0BB, 1, 1);
    check_eq("xch_data", 32'(data_out), 32'h0AA);

    // reset mid-operation with a pop in flight
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 10'h300 + 10'(i), 0, 0);
    push = 1'b0; pop = 1'b1; pop_ch = 2'd1;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    pop = 1'b0;
    check_eq("midrst_valid", 32'(valid_out), 32'h0);
    check_eq("midrst_empty1", 32'(empty[1]), 32'h1);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    step(0, 0, 0, 0, 0);

    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      int pprob, qprob;
      pprob = ((i / 150) % 2 == 0) ? 80 : 30;
      qprob = ((i / 150) % 2 == 0) ? 30 : 80;
      step(($urandom_range(99) < pprob), 2'($urandom_range(3)), 10'($urandom),
           ($urandom_range(99) < qprob), 2'($urandom_range(3)));
      if (i == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
